// File: rtl/vmask_pkg.sv
// Shared types and helpers for the vcpop.m / vfirst.m mask-reduction sequencer.
package vmask_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CHUNK    = 64;
    localparam int VLEN_DEF = 256;
    localparam int NCHUNK   = VLEN_DEF / CHUNK;
    localparam int CNT_W    = $clog2(VLEN_DEF) + 1;
    localparam int IDX_W    = $clog2(VLEN_DEF);

    // Lowest set bit wins; returns 0 for an all-zero vector.
    function automatic logic [5:0] prio_enc64(input logic [63:0] vec);
        logic [5:0] idx;
        idx = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 6'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vmask_popcnt_seq_popcnt64_csa.sv
// 64-input population count: 3:2 carry-save reduction down to two 7-bit vectors, then one add.
module popcnt64_csa
    import vmask_pkg::*;
(
    input  logic [63:0] bits,
    output logic [6:0]  count
);

    localparam int LEVELS = 10;

    logic [6:0] lv [0:LEVELS][0:63];
    logic [6:0] sum_vec;
    logic [6:0] carry_vec;

    function automatic logic [6:0] csa_sum(input logic [6:0] a, input logic [6:0] b,
                                           input logic [6:0] c);
        return a ^ b ^ c;
    endfunction

    // Carry vector wraps mod 128; the true total never exceeds 64 so the final add is exact.
    function automatic logic [6:0] csa_carry(input logic [6:0] a, input logic [6:0] b,
                                             input logic [6:0] c);
        logic [6:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[5:0], 1'b0};
    endfunction

    // Reduction tree: each level compresses groups of three operands into two.
    always_comb begin
        int n;
        int m;
        for (int l = 0; l <= LEVELS; l++) begin
            for (int j = 0; j < 64; j++) begin
                lv[l][j] = 7'd0;
            end
        end
        for (int j = 0; j < 64; j++) begin
            lv[0][j] = {6'd0, bits[j]};
        end
        n = 64;
        for (int l = 0; l < LEVELS; l++) begin
            m = 0;
            for (int g = 0; g < 22; g++) begin
                if (3 * g + 2 < n) begin
                    lv[l + 1][m]     = csa_sum(lv[l][3 * g], lv[l][3 * g + 1], lv[l][3 * g + 2]);
                    lv[l + 1][m + 1] = csa_carry(lv[l][3 * g], lv[l][3 * g + 1], lv[l][3 * g + 2]);
                    m = m + 2;
                end else if (3 * g < n) begin
                    for (int r = 0; r < 2; r++) begin
                        if (3 * g + r < n) begin
                            lv[l + 1][m] = lv[l][3 * g + r];
                            m = m + 1;
                        end else begin
                            m = m;
                        end
                    end
                end else begin
                    m = m;
                end
            end
            n = m;
        end
        sum_vec   = lv[LEVELS][0];
        carry_vec = lv[LEVELS][1];
    end

    assign count = sum_vec + carry_vec;

endmodule

// File: rtl/vmask_popcnt_seq.sv
// vcpop.m / vfirst.m sequencer: latches the gated mask, walks it one 64-bit chunk per cycle.
module vmask_popcnt_seq
    import vmask_pkg::*;
#(
    parameter int VLEN = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [VLEN-1:0]           mask_i,
    input  logic [VLEN-1:0]           v0_i,
    input  logic                      vm_i,
    input  logic [$clog2(VLEN):0]     vl_i,
    input  logic                      kill_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [$clog2(VLEN):0]     count_o,
    output logic                      first_found_o,
    output logic [$clog2(VLEN)-1:0]   first_idx_o
);

    localparam int NCH      = VLEN / CHUNK;
    localparam int CNT_BITS = $clog2(VLEN) + 1;
    localparam int IDX_BITS = $clog2(VLEN);
    localparam int K_BITS   = (NCH > 1) ? $clog2(NCH) : 1;

    state_t              state_r;
    logic [VLEN-1:0]     eff_r;
    logic [K_BITS-1:0]   k_r;
    logic [K_BITS-1:0]   last_r;

    logic [CNT_BITS-1:0] vl_eff_s;
    logic [CNT_BITS-1:0] vl_m1_s;
    logic [VLEN-1:0]     eff_s;
    logic [K_BITS-1:0]   last_s;
    logic                vl_zero_s;
    logic [63:0]         chunk_s;
    logic [6:0]          chunk_cnt_s;
    logic [5:0]          chunk_lsb_s;

    // Clamp vl, gate the source mask with v0 and the tail, and find the final chunk index.
    always_comb begin
        eff_s    = '0;
        vl_eff_s = (vl_i > CNT_BITS'(VLEN)) ? CNT_BITS'(VLEN) : vl_i;
        vl_m1_s  = vl_eff_s - CNT_BITS'(1);
        for (int i = 0; i < VLEN; i++) begin
            eff_s[i] = mask_i[i] & (vm_i | v0_i[i]) & (CNT_BITS'(i) < vl_eff_s);
        end
        if (vl_eff_s == CNT_BITS'(0)) begin
            vl_zero_s = 1'b1;
            last_s    = '0;
        end else begin
            vl_zero_s = 1'b0;
            last_s    = K_BITS'(vl_m1_s >> 6);
        end
    end

    // The stored mask is shifted down each RUN cycle, so the live chunk is always the low 64 bits.
    assign chunk_s     = eff_r[63:0];
    assign chunk_lsb_s = prio_enc64(chunk_s);

    popcnt64_csa u_popcnt (
        .bits  (chunk_s),
        .count (chunk_cnt_s)
    );

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            ready_o       <= 1'b1;
            valid_o       <= 1'b0;
            count_o       <= '0;
            first_found_o <= 1'b0;
            first_idx_o   <= '0;
            k_r           <= '0;
            last_r        <= '0;
            eff_r         <= '0;
        end else if (kill_i) begin
            state_r       <= IDLE;
            ready_o       <= 1'b1;
            valid_o       <= 1'b0;
            count_o       <= '0;
            first_found_o <= 1'b0;
            first_idx_o   <= '0;
            k_r           <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        eff_r         <= eff_s;
                        last_r        <= last_s;
                        count_o       <= '0;
                        first_found_o <= 1'b0;
                        first_idx_o   <= '0;
                        k_r           <= '0;
                        ready_o       <= 1'b0;
                        state_r       <= vl_zero_s ? DONE : RUN;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                RUN: begin
                    count_o <= count_o + CNT_BITS'(chunk_cnt_s);
                    if (!first_found_o && (chunk_s != 64'd0)) begin
                        first_found_o <= 1'b1;
                        first_idx_o   <= IDX_BITS'({k_r, chunk_lsb_s});
                    end else begin
                        first_found_o <= first_found_o;
                    end
                    eff_r <= eff_r >> CHUNK;
                    k_r   <= k_r + K_BITS'(1);
                    if (k_r == last_r) begin
                        state_r <= DONE;
                        valid_o <= 1'b1;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    // Entered with valid_o low only from a vl=0 accept; raise it one cycle later.
                    if (!valid_o) begin
                        valid_o <= 1'b1;
                    end else if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        valid_o <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vmask_popcnt_seq.sv
// Randomized and directed bench for vmask_popcnt_seq against a per-element reference model.
module tb_vmask_popcnt_seq;

    localparam int VLEN = 256;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [VLEN-1:0]  mask_i = '0;
    logic [VLEN-1:0]  v0_i = '0;
    logic             vm_i = 1'b1;
    logic [8:0]       vl_i = '0;
    logic             kill_i = 1'b0;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [8:0]       count_o;
    logic             first_found_o;
    logic [7:0]       first_idx_o;

    int n_checks = 0;
    int n_fail   = 0;

    vmask_popcnt_seq #(.VLEN(VLEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .mask_i        (mask_i),
        .v0_i          (v0_i),
        .vm_i          (vm_i),
        .vl_i          (vl_i),
        .kill_i        (kill_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .count_o       (count_o),
        .first_found_o (first_found_o),
        .first_idx_o   (first_idx_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        for (int w = 0; w < VLEN / 32; w++) begin
            v[w * 32 +: 32] = $urandom;
        end
        return v;
    endfunction

    // Reference: walk active elements in order, counting and remembering the first.
    task automatic model(input logic [VLEN-1:0] m, input logic [VLEN-1:0] v0, input logic vm,
                         input int vl_in, output int cnt, output int found, output int idx,
                         output int lat);
        int vl;
        vl = (vl_in > VLEN) ? VLEN : vl_in;
        cnt = 0; found = 0; idx = 0;
        for (int i = 0; i < vl; i++) begin
            if (m[i] && (vm || v0[i])) begin
                cnt++;
                if (found == 0) begin
                    found = 1;
                    idx = i;
                end
            end
        end
        lat = (vl + 63) / 64;
        if (lat < 1) lat = 1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready_o) check_eq("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept(input logic [VLEN-1:0] m, input logic [VLEN-1:0] v0, input logic vm,
                          input int vl);
        wait_ready();
        mask_i = m; v0_i = v0; vm_i = vm; vl_i = 9'(vl); valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        mask_i = rand_vec(); v0_i = rand_vec(); vm_i = 1'($urandom); vl_i = 9'($urandom);
    endtask

    task automatic run_op(input string name, input logic [VLEN-1:0] m, input logic [VLEN-1:0] v0,
                          input logic vm, input int vl, input int hold);
        int e_cnt, e_found, e_idx, e_lat, lat;
        model(m, v0, vm, vl, e_cnt, e_found, e_idx, e_lat);
        accept(m, v0, vm, vl);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!valid_o && lat < 20);
        if (!valid_o) begin
            check_eq({name, "_valid_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({name, "_latency"}, lat, e_lat);
        check_eq({name, "_count"}, count_o, e_cnt);
        check_eq({name, "_found"}, first_found_o, e_found);
        check_eq({name, "_idx"}, first_idx_o, e_idx);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({name, "_hold_valid"}, valid_o, 32'd1);
            check_eq({name, "_hold_ready"}, ready_o, 32'd0);
            check_eq({name, "_hold_count"}, count_o, e_cnt);
            check_eq({name, "_hold_idx"}, first_idx_o, e_idx);
        end
        // A request offered during the handoff cycle must not be taken.
        ready_i = 1'b1;
        valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready_i = 1'b0;
        valid_i = 1'b0;
        check_eq({name, "_handoff_valid"}, valid_o, 32'd0);
        check_eq({name, "_handoff_ready"}, ready_o, 32'd1);
    endtask

    initial begin
        logic [VLEN-1:0] m;
        logic [VLEN-1:0] v0;
        int seen;
        int bits_set;
        int b;
        int vl;

        repeat (2) @(negedge clk);
        check_eq("rst_ready", ready_o, 32'd1);
        check_eq("rst_valid", valid_o, 32'd0);
        check_eq("rst_count", count_o, 32'd0);
        check_eq("rst_found", first_found_o, 32'd0);
        check_eq("rst_idx", first_idx_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("all_ones", {VLEN{1'b1}}, '0, 1'b1, 256, 0);
        m = '0; m[3] = 1'b1; m[70] = 1'b1; m[99] = 1'b1; m[150] = 1'b1;
        run_op("vl100", m, '0, 1'b1, 100, 1);
        v0 = '0; v0[130] = 1'b1; v0[200] = 1'b1;
        run_op("v0_gate", {VLEN{1'b1}}, v0, 1'b0, 256, 0);
        run_op("vl_zero", {VLEN{1'b1}}, '0, 1'b1, 0, 0);
        m = '0; m[255] = 1'b1; m[200] = 1'b1;
        run_op("vl_clamp", m, '0, 1'b1, 300, 0);
        run_op("hold5", rand_vec(), rand_vec(), 1'b0, 200, 5);
        run_op("none_set", '0, '0, 1'b1, 256, 0);

        // Kill during the second RUN cycle.
        accept({VLEN{1'b1}}, '0, 1'b1, 256);
        @(posedge clk);
        @(negedge clk);
        kill_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill_i = 1'b0;
        check_eq("kill_ready", ready_o, 32'd1);
        check_eq("kill_count", count_o, 32'd0);
        check_eq("kill_found", first_found_o, 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (valid_o) seen = 1;
        end
        check_eq("kill_no_valid", seen, 32'd0);
        m = '0;
        bits_set = 0;
        while (bits_set < 17) begin
            b = $urandom_range(0, VLEN - 1);
            if (!m[b]) begin
                m[b] = 1'b1;
                bits_set++;
            end
        end
        run_op("after_kill", m, '0, 1'b1, 256, 0);

        // Kill beats a simultaneous valid in IDLE.
        wait_ready();
        mask_i = {VLEN{1'b1}}; vm_i = 1'b1; vl_i = 9'd64; valid_i = 1'b1; kill_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0; kill_i = 1'b0;
        check_eq("kill_idle_ready", ready_o, 32'd1);

        // Kill in DONE drops the result being handed off.
        accept({VLEN{1'b1}}, '0, 1'b1, 64);
        @(posedge clk);
        @(negedge clk);
        check_eq("kdone_valid_pre", valid_o, 32'd1);
        kill_i = 1'b1; ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill_i = 1'b0; ready_i = 1'b0;
        check_eq("kdone_valid", valid_o, 32'd0);
        check_eq("kdone_count", count_o, 32'd0);

        // Asynchronous reset mid-operation.
        accept({VLEN{1'b1}}, '0, 1'b1, 256);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_ready", ready_o, 32'd1);
        check_eq("arst_count", count_o, 32'd0);
        check_eq("arst_valid", valid_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 5))
                0:       vl = 0;
                1:       vl = $urandom_range(257, 511);
                default: vl = $urandom_range(1, 256);
            endcase
            m = rand_vec();
            if ($urandom_range(0, 1) == 1) m = m & rand_vec() & rand_vec() & rand_vec() & rand_vec();
            run_op("rand", m, rand_vec(), 1'($urandom), vl, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/vmask_popcnt_seq.md
Name: vmask_popcnt_seq

Overview:
- Multi-cycle sequencer for the RVV mask-reduction instructions vcpop.m and vfirst.m.
- Latches a VLEN-bit source mask and walks it 64 bits per cycle through one shared 64-input carry-save popcount tree, accumulating the count and locating the first set element.
- Sits in the permutation/mask unit between issue (valid/ready) and scalar writeback (valid/ready).

Parameters:
- VLEN, 256, mask length in bits; must be a multiple of 64, minimum 64.
- CHUNK, 64, bits processed per cycle; fixed, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  request valid
- ready_o  out  1  sequencer can accept a request
- mask_i  in  VLEN  source mask vs2
- v0_i  in  VLEN  v0 mask
- vm_i  in  1  1 = unmasked; 0 = gate elements with v0
- vl_i  in  $clog2(VLEN)+1  active element count
- kill_i  in  1  synchronous abort (pipeline flush)
- valid_o  out  1  result valid
- ready_i  in  1  writeback accepts result
- count_o  out  $clog2(VLEN)+1  vcpop.m result
- first_found_o  out  1  at least one active set bit exists
- first_idx_o  out  $clog2(VLEN)  index of lowest active set bit; 0 when not found

Behaviour:
- Reset (asynchronous): state=IDLE, ready_o=1, valid_o=0, count_o=0, first_found_o=0, first_idx_o=0, chunk index k=0.
- Effective bit i = mask_i[i] & (vm_i | v0_i[i]) & (i < vl), where vl = min(vl_i, VLEN).
- The effective mask is computed once at accept and stored in a VLEN-bit register.
- IDLE:
  - ready_o=1.
  - On valid_i & ready_o: latch the effective mask and vl, clear the accumulators, k=0.
  - Next state is RUN, or DONE directly if vl=0.
- RUN:
  - ready_o=0.
  - Each cycle, chunk k (bits 64k..64k+63) feeds the popcount tree; the tree's two 7-bit partial vectors are summed and added to the accumulator.
  - If first_found is still 0 and the chunk is nonzero: first_found<=1, first_idx <= 64k + priority-encode(chunk, lowest bit).
  - k increments each cycle. After the last needed chunk, where (k+1)*64 >= vl, state goes to DONE. Chunks beyond vl are never processed.
- Latency: N = ceil(vl/64) RUN cycles; valid_o rises on the edge ending the last RUN cycle. For vl=0, valid_o rises on the edge after the accept edge.
- DONE:
  - valid_o=1.
  - Outputs hold stable until ready_i.
  - On valid_o & ready_i: valid_o<=0, state=IDLE, ready_o=1 next cycle. Back-to-back acceptance is not allowed in the same cycle as result handoff.
- kill_i:
  - In any state, forces the next state to IDLE, valid_o<=0, accumulators cleared.
  - kill_i has priority over valid_i and ready_i in the same cycle; a result being handed off in that cycle is dropped.
- vl_i > VLEN: clamped to VLEN, no error.
- Count width: the accumulator never overflows (max VLEN fits $clog2(VLEN)+1 bits). Each chunk sum is 0..64 and fits in 7 bits.
- Inputs are sampled only on the accept edge; later changes to mask_i/v0_i/vl_i are ignored.
- rst asserted mid-operation: immediate return to the reset values above.

Decomposition:
- Package vmask_pkg:
  - state enum {IDLE, RUN, DONE}.
  - localparams NCHUNK=VLEN/64, CNT_W=$clog2(VLEN)+1, IDX_W=$clog2(VLEN).
  - Function prio_enc64 (lowest-set-bit index, 6 bits).
- Sub-module popcnt64_csa:
  - Combinational.
  - Wraps the team's 64x1 full/half-adder reduction tree, which produces two 7-bit carry-save vectors, plus a final 7-bit add.
  - Output: a 7-bit count.
  - The sequencer instantiates exactly one.

Test Plan:
- VLEN=256, vm=1, vl=256, mask all ones -> valid_o 4 cycles after accept; count_o=256, first_found_o=1, first_idx_o=0.
- vl=100, mask bits {3, 70, 99, 150} set, vm=1 -> 2 RUN cycles; count_o=3 (bit 150 excluded), first_idx_o=3.
- vm=0, mask=all ones, v0 with only bits 130 and 200 set, vl=256 -> count_o=2, first_idx_o=130.
- vl=0 -> valid_o on the cycle after accept; count_o=0, first_found_o=0. Also vl_i=300 -> behaves as vl=256.
- Hold ready_i=0 for 5 cycles in DONE -> outputs stable and ready_o=0 throughout; ready_i=1 -> IDLE, next request accepted the following cycle.
- Assert kill_i during the 2nd RUN cycle -> IDLE next cycle and valid_o never asserts. A new request (popcount 17) then returns count_o=17 with no residue from the killed operation.
